// File: rtl/bsg_launch_sync_toggle_rx.sv
// bsg_launch_sync_toggle_rx
//   Receive side of a toggle-handshake clock-domain crossing. The remote
//   sender launches data_i together with a level change on req_toggle_i.
//   This block synchronizes the toggle into clk_i and captures data_i. It
//   presents the data as a valid/yumi stream, and on consume it flips
//   ack_toggle_o straight from a flop back to the sender.
//
// Ports
//   clk_i, reset_i   destination clock; async active-high reset
//   req_toggle_i     async request toggle, one level change per transaction
//   data_i           async bundled data, stable from req toggle until ack
//   ack_toggle_o     acknowledge toggle, driven directly from a flop
//   v_o / data_o     captured data valid / registered captured data
//   yumi_i           consumer takes data_o this cycle (only while v_o)
//   err_o            sticky: sender toggled again before being acked
module bsg_launch_sync_toggle_rx #(
    parameter int width_p       = 8,
    parameter int sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_toggle_i,
    input  logic [width_p-1:0] data_i,
    output logic               ack_toggle_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               err_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [sync_stages_p-1:0] sync_q;
    logic                     sync_r;
    logic [0:0]               state_q, state_d;
    logic                     last_req_q, last_req_d;
    logic [width_p-1:0]       data_q, data_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic                     new_req;

    // Plain flop chain. Stage 0 is the only reader of req_toggle_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[sync_stages_p-2:0], req_toggle_i};
    end

    assign sync_r  = sync_q[sync_stages_p-1];
    assign new_req = sync_r ^ last_req_q;

    always_comb begin
        state_d    = state_q;
        last_req_d = last_req_q;
        data_d     = data_q;
        ack_d      = ack_q;
        err_d      = err_q;
        if (state_q == IDLE) begin
            // data_i is known stable here: the synchronized toggle proves the
            // sender launched it several cycles ago and cannot move until acked.
            if (new_req) begin
                data_d     = data_i;
                last_req_d = sync_r;
                state_d    = FULL;
            end
        end else begin
            // A second toggle while full is a sender bug. Flag it, but leave
            // last_req alone so the toggle is still picked up once we drain.
            if (new_req) err_d = 1'b1;
            if (yumi_i) begin
                ack_d   = ~ack_q;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            last_req_q <= 1'b0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_req_q <= last_req_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign ack_toggle_o = ack_q;
    assign v_o          = (state_q == FULL);
    assign data_o       = data_q;
    assign err_o        = err_q;

endmodule
